// File: rtl/decode_stage.sv
// RV32 decode pipeline stage: input skid FIFO, flush, and registered decoded bundle.
// Latency 1 cycle through an empty stage; throughput 1 instruction/cycle.
// Backpressure: if_ready comes only from the registered FIFO count; outputs hold while id_valid && !id_ready.

// Generic synchronous FIFO storing payloads without reset.
// Latency: an entry pushed at one edge can be popped from the next cycle; pop_dat is combinational from the head.
// Backpressure: the caller must not push when count == DEPTH or pop when count == 0.
module sync_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_rdy)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_vld) - CW'(pop_rdy);
        end
    end

    assign pop_dat = mem[rd_ptr];
endmodule

// Decode stage top: loads the slot from the FIFO head, or bypasses the incoming instruction.
// Latency: 1 cycle from accept to id_valid when the stage is empty.
// Backpressure: stalled bundle holds; the FIFO absorbs up to BUF_DEPTH extra instructions.
module decode_stage #(
    parameter int XLEN        = 32,
    parameter int BUF_DEPTH   = 2,
    parameter int SUPPORT_M   = 1,
    parameter int SUPPORT_CSR = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic            id_rs1_rd,
    output logic            id_rs2_rd,
    output logic            id_reg_wen,
    output logic [XLEN-1:0] id_imm,
    output logic [3:0]      id_alu_op,
    output logic            id_mul_instr,
    output logic [2:0]      id_mul_op,
    output logic            id_mem_rd,
    output logic            id_mem_wr,
    output logic [2:0]      id_mem_op,
    output logic            id_br,
    output logic            id_jal,
    output logic            id_jalr,
    output logic            id_op1_zero,
    output logic            id_op1_pc,
    output logic            id_op2_4,
    output logic            id_sel_imm,
    output logic            id_csr_rd,
    output logic [1:0]      id_csr_wr_op,
    output logic [11:0]     id_csr_addr,
    output logic            id_ill_instr
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rs1_rd;
        logic            rs2_rd;
        logic            reg_wen;
        logic [3:0]      alu_op;
        logic            mul_instr;
        logic [2:0]      mul_op;
        logic            mem_rd;
        logic            mem_wr;
        logic [2:0]      mem_op;
        logic            br;
        logic            jal;
        logic            jalr;
        logic            op1_zero;
        logic            op1_pc;
        logic            op2_4;
        logic            sel_imm;
        logic            csr_rd;
        logic [1:0]      csr_wr_op;
        logic [11:0]     csr_addr;
        logic            ill_instr;
    } dec_t;

    logic [CW-1:0]     fifo_cnt;
    logic [2*XLEN-1:0] fifo_head;
    logic              fifo_nempty;
    logic              accept;
    logic              slot_free;
    logic              load;
    logic              fifo_push;
    logic              fifo_pop;
    logic [XLEN-1:0]   src_instr;
    logic [XLEN-1:0]   src_pc;
    dec_t              dec;
    dec_t              slot_q;
    logic              valid_q;

    assign if_ready    = (fifo_cnt < CW'(BUF_DEPTH));
    assign fifo_nempty = (fifo_cnt != '0);
    assign accept      = if_valid && if_ready && !flush;
    assign slot_free   = !valid_q || id_ready;
    assign load        = slot_free && (fifo_nempty || accept);
    // An accepted instruction goes straight to the slot only when nothing older is queued.
    assign fifo_push   = accept && !(slot_free && !fifo_nempty);
    assign fifo_pop    = slot_free && fifo_nempty && !flush;
    assign src_instr   = fifo_nempty ? fifo_head[XLEN-1:0]      : if_instr;
    assign src_pc      = fifo_nempty ? fifo_head[2*XLEN-1:XLEN] : if_pc;

    sync_fifo #(
        .W     (2*XLEN),
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push_vld (fifo_push),
        .push_dat ({if_pc, if_instr}),
        .pop_rdy  (fifo_pop),
        .pop_dat  (fifo_head),
        .count    (fifo_cnt)
    );

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            ill;

    assign opc   = src_instr[6:0];
    assign f3    = src_instr[14:12];
    assign f7    = src_instr[31:25];
    assign imm_i = {{20{src_instr[31]}}, src_instr[31:20]};
    assign imm_s = {{20{src_instr[31]}}, src_instr[31:25], src_instr[11:7]};
    assign imm_b = {{19{src_instr[31]}}, src_instr[31], src_instr[7], src_instr[30:25], src_instr[11:8], 1'b0};
    assign imm_u = {src_instr[31:12], 12'b0};
    assign imm_j = {{11{src_instr[31]}}, src_instr[31], src_instr[19:12], src_instr[20], src_instr[30:21], 1'b0};

    always_comb begin
        dec          = '0;
        ill          = 1'b0;
        dec.pc       = src_pc;
        dec.instr    = src_instr;
        dec.rd       = src_instr[11:7];
        dec.rs1      = src_instr[19:15];
        dec.rs2      = src_instr[24:20];
        dec.csr_addr = src_instr[31:20];
        case (opc)
            OPC_OP: begin
                dec.rs1_rd  = 1'b1;
                dec.rs2_rd  = 1'b1;
                dec.reg_wen = 1'b1;
                case (f7)
                    7'b0000000: dec.alu_op = {1'b0, f3};
                    7'b0100000: begin
                        dec.alu_op = {1'b1, f3};
                        if (f3 != 3'b000 && f3 != 3'b101) ill = 1'b1;
                    end
                    7'b0000001: begin
                        dec.mul_instr = 1'b1;
                        dec.mul_op    = f3;
                        if (SUPPORT_M == 0) ill = 1'b1;
                    end
                    default: ill = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec.rs1_rd  = 1'b1;
                dec.reg_wen = 1'b1;
                dec.sel_imm = 1'b1;
                dec.imm     = imm_i;
                dec.alu_op  = {1'b0, f3};
                if (f3 == 3'b001 && f7 != 7'b0000000) ill = 1'b1;
                if (f3 == 3'b101) begin
                    dec.alu_op[3] = f7[5];
                    if (f7 != 7'b0000000 && f7 != 7'b0100000) ill = 1'b1;
                end
            end
            OPC_LOAD: begin
                dec.rs1_rd  = 1'b1;
                dec.reg_wen = 1'b1;
                dec.mem_rd  = 1'b1;
                dec.mem_op  = f3;
                dec.sel_imm = 1'b1;
                dec.imm     = imm_i;
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
            end
            OPC_STORE: begin
                dec.rs1_rd  = 1'b1;
                dec.rs2_rd  = 1'b1;
                dec.mem_wr  = 1'b1;
                dec.mem_op  = f3;
                dec.sel_imm = 1'b1;
                dec.imm     = imm_s;
                if (f3 >= 3'b011) ill = 1'b1;
            end
            OPC_BRANCH: begin
                dec.rs1_rd = 1'b1;
                dec.rs2_rd = 1'b1;
                dec.br     = 1'b1;
                dec.imm    = imm_b;
                if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
            end
            OPC_JALR: begin
                dec.rs1_rd  = 1'b1;
                dec.reg_wen = 1'b1;
                dec.jalr    = 1'b1;
                dec.op1_pc  = 1'b1;
                dec.op2_4   = 1'b1;
                dec.imm     = imm_i;
                if (f3 != 3'b000) ill = 1'b1;
            end
            OPC_JAL: begin
                dec.reg_wen = 1'b1;
                dec.jal     = 1'b1;
                dec.op1_pc  = 1'b1;
                dec.op2_4   = 1'b1;
                dec.imm     = imm_j;
            end
            OPC_LUI: begin
                dec.reg_wen  = 1'b1;
                dec.op1_zero = 1'b1;
                dec.sel_imm  = 1'b1;
                dec.imm      = imm_u;
            end
            OPC_AUIPC: begin
                dec.reg_wen = 1'b1;
                dec.op1_pc  = 1'b1;
                dec.sel_imm = 1'b1;
                dec.imm     = imm_u;
            end
            OPC_SYSTEM: begin
                // Immediate CSR forms carry the zero-extended rs1 field as the operand.
                dec.reg_wen   = 1'b1;
                dec.rs1_rd    = !f3[2];
                dec.sel_imm   = f3[2];
                dec.imm       = {27'b0, src_instr[19:15]};
                dec.csr_rd    = (f3[1:0] != 2'b01) || (src_instr[11:7] != 5'd0);
                dec.csr_wr_op = (f3[1] && src_instr[19:15] == 5'd0) ? 2'b00 : f3[1:0];
                if (f3[1:0] == 2'b00 || SUPPORT_CSR == 0) ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (src_instr[1:0] != 2'b11) ill = 1'b1;
        if (ill) begin
            dec.reg_wen   = 1'b0;
            dec.mem_rd    = 1'b0;
            dec.mem_wr    = 1'b0;
            dec.br        = 1'b0;
            dec.jal       = 1'b0;
            dec.jalr      = 1'b0;
            dec.mul_instr = 1'b0;
            dec.csr_rd    = 1'b0;
            dec.csr_wr_op = 2'b00;
        end
        dec.ill_instr = ill;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (slot_free) begin
            valid_q <= load;
            if (load) slot_q <= dec;
        end
    end

    assign id_valid     = valid_q;
    assign id_pc        = slot_q.pc;
    assign id_instr     = slot_q.instr;
    assign id_rd        = slot_q.rd;
    assign id_rs1       = slot_q.rs1;
    assign id_rs2       = slot_q.rs2;
    assign id_rs1_rd    = slot_q.rs1_rd;
    assign id_rs2_rd    = slot_q.rs2_rd;
    assign id_reg_wen   = slot_q.reg_wen;
    assign id_imm       = slot_q.imm;
    assign id_alu_op    = slot_q.alu_op;
    assign id_mul_instr = slot_q.mul_instr;
    assign id_mul_op    = slot_q.mul_op;
    assign id_mem_rd    = slot_q.mem_rd;
    assign id_mem_wr    = slot_q.mem_wr;
    assign id_mem_op    = slot_q.mem_op;
    assign id_br        = slot_q.br;
    assign id_jal       = slot_q.jal;
    assign id_jalr      = slot_q.jalr;
    assign id_op1_zero  = slot_q.op1_zero;
    assign id_op1_pc    = slot_q.op1_pc;
    assign id_op2_4     = slot_q.op2_4;
    assign id_sel_imm   = slot_q.sel_imm;
    assign id_csr_rd    = slot_q.csr_rd;
    assign id_csr_wr_op = slot_q.csr_wr_op;
    assign id_csr_addr  = slot_q.csr_addr;
    assign id_ill_instr = slot_q.ill_instr;
endmodule
